// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock, quotient/remainder/div-by-zero out.
// Latency: DW_N cycles from acceptance to result for a nonzero divisor; zero divisor resolves at acceptance.
// Backpressure: result held in DONE until out_ready; in_ready is low whenever an operation is in flight.
module seq_divider #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = $clog2(DW_N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so after DW_N iterations this register holds the quotient.
    logic [DW_N-1:0] dvd_sr;
    logic [DW_N-1:0] q_next;
    logic [DW_D-1:0] dvs_q;
    logic [DW_D-1:0] p_q;
    logic [DW_D-1:0] p_next;
    logic [DW_D:0]   p_shift;
    logic [DW_D:0]   p_diff;
    logic            q_bit;
    logic [CW-1:0]   cnt_q;
    logic            last_iter;

    // The partial remainder is always below the divisor, so its top bit is
    // implicitly zero and only the borrow of the trial subtraction is kept.
    always_comb begin
        p_shift   = {p_q, dvd_sr[DW_N-1]};
        p_diff    = p_shift - {1'b0, dvs_q};
        q_bit     = ~p_diff[DW_D];
        p_next    = q_bit ? p_diff[DW_D-1:0] : p_shift[DW_D-1:0];
        q_next    = {dvd_sr[DW_N-2:0], q_bit};
        last_iter = (cnt_q == CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Result registers load only on entry to DONE; they hold through IDLE/CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sr      <= '0;
            dvs_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_sr <= dividend;
                        dvs_q  <= divisor;
                        p_q    <= '0;
                        cnt_q  <= CW'(DW_N);
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[DW_D-1:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd_sr <= q_next;
                    p_q    <= p_next;
                    cnt_q  <= cnt_q - CW'(1);
                    if (last_iter) begin
                        quotient    <= q_next;
                        remainder   <= p_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios plus randomized operations checked
// against plain integer division; a second 8/4 instance gets a full dividend sweep.
module tb_seq_divider;

    localparam int N  = 16;
    localparam int D  = 8;
    localparam int N2 = 8;
    localparam int D2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [N-1:0] dividend, quotient;
    logic [D-1:0] divisor, remainder;

    logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b, div_by_zero_b;
    logic [N2-1:0] dividend_b, quotient_b;
    logic [D2-1:0] divisor_b, remainder_b;

    int errors = 0;
    int checks = 0;

    seq_divider #(.DW_N(N), .DW_D(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    seq_divider #(.DW_N(N2), .DW_D(D2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .dividend(dividend_b), .divisor(divisor_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .quotient(quotient_b), .remainder(remainder_b), .div_by_zero(div_by_zero_b)
    );

    // Reference: integer division; zero divisor gives all-ones quotient and the
    // low dividend bits as remainder.
    function automatic void ref_div(input int unsigned n, input int unsigned d,
                                    input int nw, input int dw,
                                    output int unsigned q, output int unsigned r, output bit z);
        if (d == 0) begin
            q = (1 << nw) - 1;
            r = n % (1 << dw);
            z = 1'b1;
        end else begin
            q = n / d;
            r = n % d;
            z = 1'b0;
        end
    endfunction

    task automatic send(input logic [N-1:0] n, input logic [D-1:0] d);
        int t;
        t = 0;
        @(negedge clk);
        dividend = n;
        divisor  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b after %0d cycles, expected 1", in_ready, t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout: out_valid=%b after %0d cycles, expected 1", out_valid, lat);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; dividend_b = '0; divisor_b = '0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (quotient !== '0)    begin errors++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
        if (remainder !== '0)   begin errors++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        send(16'd1000, 8'd7);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: in_ready=%b expected 0", in_ready); end
        wait_result(lat);
        checks += 4;
        if (lat != 16)            begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
        if (quotient !== 16'd142) begin errors++; $display("FAIL basic_q: got %0d expected 142", quotient); end
        if (remainder !== 8'd6)   begin errors++; $display("FAIL basic_r: got %0d expected 6", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
        release_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_extremes();
        logic [N-1:0] n_tab [3] = '{16'hFFFF, 16'hFFFF, 16'd5};
        logic [D-1:0] d_tab [3] = '{8'hFF, 8'h01, 8'd10};
        logic [N-1:0] q_tab [3] = '{16'h0101, 16'hFFFF, 16'd0};
        logic [D-1:0] r_tab [3] = '{8'd0, 8'd0, 8'd5};
        int lat;
        for (int i = 0; i < 3; i++) begin
            send(n_tab[i], d_tab[i]);
            wait_result(lat);
            checks += 3;
            if (quotient !== q_tab[i]) begin errors++; $display("FAIL extreme_q[%0d]: got %h expected %h", i, quotient, q_tab[i]); end
            if (remainder !== r_tab[i]) begin errors++; $display("FAIL extreme_r[%0d]: got %h expected %h", i, remainder, r_tab[i]); end
            if (div_by_zero !== 1'b0) begin errors++; $display("FAIL extreme_dbz[%0d]: got %b expected 0", i, div_by_zero); end
            release_result();
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        send(16'h1234, 8'd0);
        wait_result(lat);
        checks += 4;
        // Result is already visible in the cycle right after the acceptance edge.
        if (lat != 0)              begin errors++; $display("FAIL dbz_latency: extra cycles %0d expected 0", lat); end
        if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dbz_q: got %h expected ffff", quotient); end
        if (remainder !== 8'h34)   begin errors++; $display("FAIL dbz_r: got %h expected 34", remainder); end
        if (div_by_zero !== 1'b1)  begin errors++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int t;
        @(negedge clk);
        dividend = 16'd300; divisor = 8'd9;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (in_ready) acc.push_back(cyc);
            if (out_valid) begin
                checks++;
                if (quotient !== 16'd33 || remainder !== 8'd3) begin
                    errors++;
                    $display("FAIL b2b_result: got q=%0d r=%0d expected 33/3", quotient, remainder);
                end
            end
        end
        in_valid = 1'b0;
        checks += 2;
        if (acc.size() < 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d acceptances expected at least 3", acc.size());
            checks--;
        end else begin
            if (acc[1] - acc[0] != N + 2) begin errors++; $display("FAIL b2b_interval0: got %0d expected %0d", acc[1] - acc[0], N + 2); end
            if (acc[2] - acc[1] != N + 2) begin errors++; $display("FAIL b2b_interval1: got %0d expected %0d", acc[2] - acc[1], N + 2); end
        end
        t = 0;
        while (!in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        send(16'd1000, 8'd7);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            dividend = N'($urandom);
            divisor  = D'($urandom_range(1, 255));
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd142 ||
                remainder !== 8'd6 || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ov=%b ir=%b q=%0d r=%0d z=%b expected 1/0/142/6/0",
                         i, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
        end
        @(negedge clk);
        in_valid = 1'b1; dividend = 16'd77; divisor = 8'd0;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL handshake_in_ready: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        send(16'd77, 8'd11);
        wait_result(lat);
        checks++;
        if (quotient !== 16'd7 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL after_stall: got q=%0d r=%0d z=%b expected 7/0/0", quotient, remainder, div_by_zero);
        end
        release_result();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit seen;
        send(16'd500, 8'd3);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 ||
            remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: ir=%b ov=%b q=%h r=%h z=%b expected 1/0/0/0/0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midop_ghost: out_valid seen=1 expected 0"); end
        send(16'd200, 8'd13);
        wait_result(lat);
        checks++;
        if (quotient !== 16'd15 || remainder !== 8'd5 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midop_next: got q=%0d r=%0d z=%b expected 15/5/0", quotient, remainder, div_by_zero);
        end
        release_result();
    endtask

    task automatic test_random();
        int unsigned n, d, sel, q, r;
        bit z;
        int lat;
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 15);
            n = (sel[0]) ? $urandom_range(0, 300) : $urandom_range(0, 65535);
            d = (sel == 0) ? 0 : (sel < 5) ? $urandom_range(1, 3) : $urandom_range(1, 255);
            ref_div(n, d, N, D, q, r, z);
            send(N'(n), D'(d));
            wait_result(lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (quotient !== N'(q) || remainder !== D'(r) || div_by_zero !== z ||
                lat != (z ? 0 : N)) begin
                errors++;
                $display("FAIL random[%0d] %0d/%0d: got q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b",
                         i, n, d, quotient, remainder, div_by_zero, lat, q, r, z);
            end
            release_result();
        end
    endtask

    task automatic test_sweep();
        int unsigned d, q, r;
        bit z;
        int t, lat;
        for (int n = 0; n < 256; n++) begin
            for (int k = 0; k < 4; k++) begin
                d = (n + k * 4) % 16;
                ref_div(n, d, N2, D2, q, r, z);
                @(negedge clk);
                dividend_b = N2'(n); divisor_b = D2'(d); in_valid_b = 1'b1;
                t = 0;
                while (!in_ready_b && t < 32) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                in_valid_b = 1'b0;
                lat = 0;
                while (!out_valid_b && lat < 32) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                checks++;
                if (out_valid_b !== 1'b1 || quotient_b !== N2'(q) || remainder_b !== D2'(r) ||
                    div_by_zero_b !== z || lat != (z ? 0 : N2)) begin
                    errors++;
                    $display("FAIL sweep %0d/%0d: got ov=%b q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b",
                             n, d, out_valid_b, quotient_b, remainder_b, div_by_zero_b, lat, q, r, z);
                end
                out_ready_b = 1'b1;
                @(posedge clk);
                #1;
                out_ready_b = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
